// File: rtl/fg_sample_sequencer_if.sv
// rtl/fg_sample_sequencer_if.sv - waveform RAM read port and interpolator-facing sample bus
interface fg_sample_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] Rd_addr;
  logic [DATA_W-1:0] Rd_data;
  logic [DATA_W-1:0] Out1;
  logic [DATA_W-1:0] Out2;
  logic              Enable;
  logic [2:0]        Mode_q;
  logic              Sync;

  modport master (
    output Rd_addr,
    input  Rd_data,
    output Out1,
    output Out2,
    output Enable,
    output Mode_q,
    output Sync
  );

  modport slave (
    input  Rd_addr,
    output Rd_data,
    input  Out1,
    input  Out2,
    input  Enable,
    input  Mode_q,
    input  Sync
  );
endinterface

// File: rtl/fg_sample_sequencer.sv
// rtl/fg_sample_sequencer.sv - walks the waveform table and feeds adjacent sample pairs to the interpolator
module fg_sample_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  Fg_clk,
  input  logic                  Resetn,
  input  logic                  Run,
  input  logic [2:0]            Mode,
  input  logic [ADDR_W-1:0]     Len,
  fg_sample_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, PRIME, FILL, RUN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] ptr_wrap;
  logic [13:0]       cnt_q, cnt_d;
  logic [13:0]       cnt_last;
  logic              first_q, first_d;
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;
  logic              enable_q, enable_d;
  logic              sync_q, sync_d;
  logic [2:0]        mode_q, mode_d;
  logic              advance;

  // Len=0 makes len_q-1 all ones, so the pointer covers the full table.
  assign ptr_wrap = (ptr_q == len_q - ADDR_ONE) ? '0 : ptr_q + ADDR_ONE;

  always_comb begin
    cnt_last = 14'd0;
    case (mode_q)
      3'd1:    cnt_last = 14'd9;
      3'd2:    cnt_last = 14'd99;
      3'd3:    cnt_last = 14'd999;
      3'd4:    cnt_last = 14'd9999;
      default: cnt_last = 14'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    enable_d = 1'b0;
    sync_d   = 1'b0;
    mode_d   = mode_q;
    advance  = 1'b0;

    if (state_q != IDLE && !Run) begin
      state_d = IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      first_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ptr_d = '0;
          cnt_d = '0;
          if (Run) begin
            mode_d  = Mode;
            len_d   = Len;
            state_d = PRIME;
          end
        end
        PRIME: begin
          out1_d  = bus.Rd_data;
          first_d = 1'b1;
          ptr_d   = ptr_wrap;
          state_d = FILL;
        end
        FILL: begin
          advance = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (cnt_q == cnt_last) begin
            advance = 1'b1;
            cnt_d   = '0;
            mode_d  = Mode;
          end else begin
            cnt_d = cnt_q + 14'd1;
          end
        end
      endcase
    end

    if (advance) begin
      out2_d   = out1_q;
      out1_d   = bus.Rd_data;
      first_d  = (ptr_q == '0);
      sync_d   = first_q;
      ptr_d    = ptr_wrap;
      enable_d = 1'b1;
    end
  end

  // Addressing the RAM with the next pointer keeps Rd_data == mem[ptr_q] every cycle.
  assign bus.Rd_addr = ptr_d;
  assign bus.Out1    = out1_q;
  assign bus.Out2    = out2_q;
  assign bus.Enable  = enable_q;
  assign bus.Sync    = sync_q;
  assign bus.Mode_q  = mode_q;

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      out1_q   <= '0;
      out2_q   <= '0;
      enable_q <= 1'b0;
      sync_q   <= 1'b0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      enable_q <= enable_d;
      sync_q   <= sync_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: tb/tb_fg_sample_sequencer.sv
// tb/tb_fg_sample_sequencer.sv - scoreboard bench for fg_sample_sequencer with a 16-entry table
module tb_fg_sample_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef struct {
    logic [DATA_W-1:0] o2;
    logic [DATA_W-1:0] o1;
    logic              sy;
  } exp_t;

  logic              Fg_clk;
  logic              Resetn;
  logic              Run;
  logic [2:0]        Mode;
  logic [ADDR_W-1:0] Len;
  logic [DATA_W-1:0] mem [16];
  exp_t              sbq [$];
  int                tests;
  int                fails;

  fg_sample_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fg_sample_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Fg_clk (Fg_clk),
    .Resetn (Resetn),
    .Run    (Run),
    .Mode   (Mode),
    .Len    (Len),
    .bus    (bus)
  );

  initial Fg_clk = 1'b0;
  always #5 Fg_clk = ~Fg_clk;

  always @(posedge Fg_clk) bus.Rd_data <= mem[bus.Rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] o2, input logic [31:0] o1, input logic sy);
    exp_t e;
    e.o2 = o2;
    e.o1 = o1;
    e.sy = sy;
    sbq.push_back(e);
  endtask

  // Each pulse must arrive exactly 'want' negedges after the previous one.
  task automatic drain(input string tag, input int first_gap, input int period);
    exp_t e;
    int   waited;
    int   want;
    want = first_gap;
    while (sbq.size() > 0) begin
      waited = 0;
      do begin
        @(negedge Fg_clk);
        waited++;
      end while (bus.Enable !== 1'b1 && waited < want + 2);
      e = sbq.pop_front();
      chk({tag, "_gap"}, waited, want);
      chk({tag, "_out2"}, bus.Out2, e.o2);
      chk({tag, "_out1"}, bus.Out1, e.o1);
      chk({tag, "_sync"}, {31'd0, bus.Sync}, {31'd0, e.sy});
      want = period;
    end
  endtask

  task automatic stop_run();
    Run = 1'b0;
    repeat (2) @(negedge Fg_clk);
  endtask

  task automatic load_abcd();
    mem[0] = 100;
    mem[1] = 200;
    mem[2] = 300;
    mem[3] = 400;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    Resetn = 1'b0;
    Run    = 1'b0;
    Mode   = 3'd0;
    Len    = '0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    repeat (3) @(negedge Fg_clk);

    chk("rst_out1", bus.Out1, 0);
    chk("rst_out2", bus.Out2, 0);
    chk("rst_enable", {31'd0, bus.Enable}, 0);
    chk("rst_sync", {31'd0, bus.Sync}, 0);
    chk("rst_mode_q", {29'd0, bus.Mode_q}, 0);
    chk("rst_rd_addr", {28'd0, bus.Rd_addr}, 0);
    Resetn = 1'b1;
    @(negedge Fg_clk);

    // Mode 1 startup and wraparound of a 4-entry table
    load_abcd();
    Mode = 3'd1;
    Len  = 4'd4;
    Run  = 1'b1;
    push(100, 200, 1);
    push(200, 300, 0);
    push(300, 400, 0);
    push(400, 100, 0);
    push(100, 200, 1);
    drain("m1", 3, 10);

    // Run dropped mid-period, then restarted from sample 0
    repeat (5) @(negedge Fg_clk);
    Run = 1'b0;
    @(negedge Fg_clk);
    chk("stop_enable", {31'd0, bus.Enable}, 0);
    chk("stop_out2", bus.Out2, 100);
    chk("stop_out1", bus.Out1, 200);
    chk("stop_rd_addr", {28'd0, bus.Rd_addr}, 0);
    Run = 1'b1;
    push(100, 200, 1);
    push(200, 300, 0);
    drain("restart", 3, 10);
    stop_run();

    // Mode 0: a new sample every clock
    mem[0] = 7;
    mem[1] = 8;
    mem[2] = 9;
    Mode = 3'd0;
    Len  = 4'd3;
    Run  = 1'b1;
    for (int k = 0; k < 7; k++)
      push(7 + (k % 3), 7 + ((k + 1) % 3), (k % 3) == 0);
    drain("m0", 3, 1);
    chk("m0_rd_addr", {28'd0, bus.Rd_addr}, 0);
    stop_run();

    // Mode change 2 -> 3 at cnt=50 takes effect only at the boundary
    load_abcd();
    Mode = 3'd2;
    Len  = 4'd4;
    Run  = 1'b1;
    push(100, 200, 1);
    drain("mc_first", 3, 100);
    repeat (50) @(negedge Fg_clk);
    Mode = 3'd3;
    chk("mc_mode_hold", {29'd0, bus.Mode_q}, 2);
    push(200, 300, 0);
    drain("mc_mid", 50, 100);
    chk("mc_mode_new", {29'd0, bus.Mode_q}, 3);
    push(300, 400, 0);
    drain("mc_long", 1000, 1000);
    stop_run();

    // Len=0 spans the whole 16-entry table
    for (int i = 0; i < 16; i++) mem[i] = i;
    Mode = 3'd0;
    Len  = 4'd0;
    Run  = 1'b1;
    for (int k = 0; k < 17; k++)
      push(k % 16, (k + 1) % 16, (k % 16) == 0);
    drain("len0", 3, 1);
    stop_run();

    // Len=1 repeats sample 0 with Sync on every pulse
    mem[0] = 55;
    Len = 4'd1;
    Run = 1'b1;
    for (int k = 0; k < 4; k++) push(55, 55, 1);
    drain("len1", 3, 1);
    stop_run();

    // Asynchronous reset during a Mode 4 pulse, then restart
    load_abcd();
    Mode = 3'd4;
    Len  = 4'd4;
    Run  = 1'b1;
    push(100, 200, 1);
    drain("m4", 3, 10000);
    Resetn = 1'b0;
    #1;
    chk("arst_enable", {31'd0, bus.Enable}, 0);
    chk("arst_sync", {31'd0, bus.Sync}, 0);
    chk("arst_out1", bus.Out1, 0);
    chk("arst_out2", bus.Out2, 0);
    chk("arst_mode_q", {29'd0, bus.Mode_q}, 0);
    @(negedge Fg_clk);
    Resetn = 1'b1;
    push(100, 200, 1);
    push(200, 300, 0);
    drain("m4_after_rst", 3, 10000);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
